// File: rtl/serial_ripple_sub.sv
// serial_ripple_sub: bit-serial ripple-borrow subtractor, diff = a - b - bin, LSB first
module serial_ripple_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_diff,
  output logic         o_bout
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state;
  logic [N-1:0]  r_sa, r_sb, r_diff;
  logic [CW-1:0] r_cnt;
  logic          r_br, r_in_ready, r_out_valid;
  logic          w_x, w_y, w_d, w_bn, w_last;
  assign w_x    = r_sa[0];
  assign w_y    = r_sb[0];
  assign w_d    = w_x ^ w_y ^ r_br;
  assign w_bn   = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last = r_cnt == CW'(N - 1);
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_diff      = r_diff;
  assign o_bout      = r_out_valid & r_br;
  // FSM and datapath: in_ready/out_valid are registered from the next state so
  // in_ready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_diff      <= '0;
      r_cnt       <= '0;
      r_br        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_sa       <= i_a;
            r_sb       <= i_b;
            r_br       <= i_bin;
            r_cnt      <= '0;
            r_diff     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          r_diff <= {w_d, r_diff[N-1:1]};
          r_br   <= w_bn;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_ripple_sub.md
# serial_ripple_sub

Bit-serial ripple-borrow subtractor: computes `diff = a - b - bin` over N-bit operands, one bit per clock, LSB first. The borrow is carried between cycles in a single flip-flop rather than rippling through N cells. It is the sequential, inverse-operation counterpart to the team's parallel ripple-carry adder, and serves area-constrained datapaths that can tolerate N-cycle latency. Operands and results move through valid/ready handshakes.

## Interface
- `N`, default 8: operand and result width. Legal range is N >= 2.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a`  in  N  minuend.
- `b`  in  N  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  N  result, `(a - b - bin) mod 2^N`.
- `bout`  out  1  borrow-out; 1 when `a < b + bin` (unsigned).

## Operation
- There is one clock. Reset is synchronous and active-low, sampled on the rising edge of `clk`.
- FSM states:
  - IDLE → RUN when `in_valid && in_ready`.
  - RUN → DONE when the bit counter equals N-1.
  - DONE → IDLE when `out_ready`.
  - DONE holds while `out_ready` is low.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE. Both are decoded from registered state.
- On accept:
  - Latch `a` into `sa` and `b` into `sb`.
  - Set `br` to `bin`.
  - Clear the bit counter `cnt` (width `$clog2(N)`).
  - Clear the `diff` register.
- Each RUN cycle, using the bit-0 values `x = sa[0]` and `y = sb[0]`:
  - Difference bit: `d = x ^ y ^ br`.
  - Next borrow: `br = (~x & y) | (~(x ^ y) & br)`.
  - Shift `sa` and `sb` right by 1.
  - Shift `diff` right by 1, inserting `d` at `diff[N-1]`.
  - Increment `cnt`.
- On the RUN → DONE edge the final borrow is written to `br`. `bout` is driven from `br`, masked to 0 outside DONE.
- `diff` and `bout` are stable for the whole DONE state, independent of input activity.
- In RUN and DONE, `in_valid`, `a`, `b` and `bin` are ignored. Operands are never queued.
- Reset mid-operation (any state):
  - Next state is IDLE.
  - `cnt`, `br`, `diff`, `sa` and `sb` are cleared.
  - Any in-flight result is discarded, and no `out_valid` pulse is produced.
- All arithmetic is unsigned modulo 2^N. Signed interpretation is left to the user: `bout` is not an overflow flag.

## Timing
- Reset values, in the cycle after a low `rst_n` edge:
  - `in_ready` = 0 while `rst_n` is held low; it becomes 1 in the first cycle after reset is released.
  - `out_valid` = 0, `diff` = 0, `bout` = 0.
- Latency: accept at edge E0; `out_valid` rises after edge EN (N RUN cycles).
- The result is held from edge EN until the edge where `out_valid && out_ready`.
- Back-to-back throughput: one operation per N+2 cycles (accept, N RUN cycles, DONE with `out_ready` high, then IDLE).
- A result handshake and a new operand accept can never coincide. IDLE is always entered for at least one cycle before the next accept.
- `in_valid` asserted during DONE while `out_ready` is high is not accepted on that edge. It is accepted on the following edge in IDLE if it is still asserted.

## Test plan
- N=8, `a`=0x5A, `b`=0x33, `bin`=0, `out_ready`=1:
  - `out_valid` rises exactly 8 cycles after accept.
  - `diff`=0x27, `bout`=0.
- `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `bout`=1.
- `a`=0x10, `b`=0x10, `bin`=1 → `diff`=0xFF, `bout`=1.
- `a`=0xFF, `b`=0x00, `bin`=1 → `diff`=0xFE, `bout`=0.
- Backpressure:
  - `a`=0x80, `b`=0x01, with `out_ready` low for 5 DONE cycles.
  - `out_valid`=1 is held, and `diff`=0x7F, `bout`=0 stay stable throughout.
  - `in_ready`=0 throughout, while `in_valid` toggles with other operands.
  - After `out_ready` goes high: one cycle later `in_ready`=1.
- Reset mid-run:
  - Assert `rst_n`=0 at RUN cycle 4 of `a`=0xAA, `b`=0x55.
  - Next cycle: `out_valid`=0, `diff`=0, `bout`=0, and `in_ready`=0 while reset is held.
  - After release: `in_ready`=1 and no result appears.
  - A new operation, 0x03-0x01, yields `diff`=0x02, `bout`=0.
- Random: 1000 random operand sets with random `out_ready` stalls, at N=8 and N=16, compared against a reference model `{bout, diff} = {1'b0, a} - {1'b0, b} - bin`.
